dac_channel_scheduler: RTL and testbench
========================================

# dac_channel_scheduler

Frame scheduler for the 24-bit serial DAC path in the drum-sample playback chain. It arbitrates round-robin among four voice channels that request DAC updates. It builds the 24-bit command word the serializer shifts out MSB-first, one bit per 2 clocks. It swaps that word exactly at the serializer's frame boundary, acknowledges the served channel, and flags loss of frame alignment.

## Interface
- `CMD`, default 4'b0011: DAC command nibble for channel writes (write and update).
- `NOP_CMD`, default 4'b1111: command nibble for idle frames (no operation).
- `clk` in 1: system clock, same clock as the serializer.
- `reset` in 1: asynchronous, active-high. It must be the same reset net as the serializer.
- `req` in 4: per-channel update request, level-sensitive. `req[i]` is channel i.
- `ch_data` in 48: channel sample values; `ch_data[12*i+11:12*i]` is channel i.
- `frame_sig` in 1: serializer last-bit indicator. It is high for exactly 2 clocks while bit 0 shifts.
- `dac_word` out 24: word presented to the serializer, `{cmd[3:0], addr[3:0], data[11:0], 4'b0000}`.
- `ack` out 4: one-cycle pulse to the channel whose sample was loaded.
- `cur_ch` out 2: channel index of the word now shifting. Valid only when `cur_valid`=1.
- `cur_valid` out 1: 1 when the current frame carries channel data, 0 for a NOP frame.
- `sync_err` out 1: sticky flag for frame misalignment. Cleared only by reset.

## Operation
- Frame = 48 clocks = 24 bits × 2 clocks. A boundary event (`bnd`) = `frame_sig` && `frame_sig_d`, where `frame_sig_d` is `frame_sig` registered one clock.
- `bnd` is true in the final clock of a frame. On that clock's rising edge, `dac_word` takes the next frame's word, so bit 23 of the new word is present on the serializer output on the following cycle.
- Local frame counter `fcnt`, 0..47:
  - reset value 0;
  - increments every clock;
  - wraps 47→0.
  - A correctly aligned `bnd` occurs exactly when `fcnt`=47.
- Alignment check:
  - If `bnd` occurs with `fcnt`≠47, or `fcnt`=47 with no `bnd`, set `sync_err`=1.
  - Then resync by forcing `fcnt`=0 on the next edge if `bnd` was true; otherwise let it wrap normally.
  - Words are loaded only on `bnd`, never on `fcnt` alone.
- Arbitration at each `bnd`, with round-robin pointer `rr` (2 bits, reset 0):
  - Search channels `rr`, `rr`+1, … mod 4 for the first `req[i]`=1.
  - Grant found:
    - `dac_word` = `{CMD, 2'b00, i[1:0], ch_data[i], 4'b0}`, using `ch_data` sampled on that edge;
    - `ack[i]`=1 for the following single cycle;
    - `cur_ch`=i, `cur_valid`=1;
    - `rr` = i+1 mod 4.
  - No requests:
    - `dac_word` = `{NOP_CMD, 4'hF, 12'h000, 4'h0}`;
    - `cur_valid`=0; `rr` and `cur_ch` unchanged;
    - no `ack`.
- A requester holding `req` high continuously is served at most once per frame. With all four requesting, the grant order is 0,1,2,3,0,…
- `req` changes between boundaries are ignored. Only the value at `bnd` matters.
- `ch_data` changes after the grant edge do not affect the word in flight.

## Timing
- Reset values: `dac_word` = NOP word (`{NOP_CMD, 4'hF, 16'h0}`), `ack`=0, `cur_ch`=0, `cur_valid`=0, `sync_err`=0, `fcnt`=0, `rr`=0, `frame_sig_d`=0.
- After reset deasserts, the first frame is always NOP. The first possible channel word loads at the first `bnd`, on clock 48 after reset release.
- Latency from `req` rising to `ack`: 1 to 48 clocks, plus up to 3 further frames of round-robin wait.
- `ack` is registered and asserts in the cycle after the `bnd` edge, coincident with the new `dac_word`.
- Reset mid-frame:
  - All state returns to reset values immediately (asynchronous).
  - Any pending `ack` is dropped and `dac_word` reverts to NOP.
  - The serializer restarts in the same cycle, so alignment holds.
- `bnd` and a `req` edge in the same cycle: the `req` value sampled on that edge counts.

## Test plan
- Reset, no `req`, 200 clocks:
  - `dac_word` = 24'hFF0000 throughout;
  - `ack`=0; `sync_err`=0;
  - `bnd` at clocks 47, 95, 143, 191.
- `req`=4'b0100 with `ch_data[35:24]`=12'hABC held from clock 10 until `ack[2]`:
  - at the edge after clock 47, `dac_word`=24'h32ABC0;
  - `ack[2]` high for 1 cycle; `cur_ch`=2.
- `req`=4'b1111 held with distinct data per channel: successive frames carry addr 0,1,2,3,0; `ack` rotates with one pulse per frame.
- `req[1]` held and `req[3]` pulsed for 1 clock mid-frame (not at `bnd`): `req[3]` is never served and channel 1 is served every frame.
- Serializer output captured 2 clocks per bit reproduces each loaded `dac_word` MSB-first with no bit slip across 10 consecutive frames.
- Inject an extra 2-clock `frame_sig` pulse at `fcnt`=20:
  - `sync_err` goes to 1 and stays 1;
  - `fcnt` resyncs to 0 after the injected `bnd`;
  - a reset pulse clears `sync_err` and returns `dac_word` to NOP.

Source files
------------

// File: rtl/dac_channel_scheduler.sv
// rtl/dac_channel_scheduler.sv - round-robin frame scheduler for the 24-bit serial DAC path
// Loads the next DAC word exactly at the serializer frame boundary and watches frame alignment.
module dac_channel_scheduler #(
  parameter logic [3:0] CMD     = 4'b0011,
  parameter logic [3:0] NOP_CMD = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [47:0] ch_data,
  input  logic        frame_sig,
  output logic [23:0] dac_word,
  output logic [3:0]  ack,
  output logic [1:0]  cur_ch,
  output logic        cur_valid,
  output logic        sync_err
);

  localparam logic [23:0] NOP_WORD = {NOP_CMD, 4'hF, 16'h0000};
  localparam logic [5:0]  FCNT_LAST = 6'd47;

  logic        frame_sig_q;
  logic [5:0]  fcnt_q, fcnt_d;
  logic [1:0]  rr_q, rr_d;
  logic [23:0] dac_word_q, dac_word_d;
  logic [3:0]  ack_q, ack_d;
  logic [1:0]  cur_ch_q, cur_ch_d;
  logic        cur_valid_q, cur_valid_d;
  logic        sync_err_q, sync_err_d;

  logic        bnd;
  logic        at_end;
  logic        grant_found;
  logic [1:0]  grant_idx;
  logic [11:0] grant_data;

  // Serializer holds frame_sig for the two clocks of bit 0; the second one closes the frame.
  assign bnd    = frame_sig & frame_sig_q;
  assign at_end = (fcnt_q == FCNT_LAST);

  // Descending scan so the channel closest to rr (offset 0) is the last writer and wins.
  always_comb begin
    logic [1:0] cand;
    grant_found = 1'b0;
    grant_idx   = rr_q;
    cand        = rr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_data = ch_data[11:0];
      2'd1:    grant_data = ch_data[23:12];
      2'd2:    grant_data = ch_data[35:24];
      default: grant_data = ch_data[47:36];
    endcase
  end

  // A boundary always restarts the local count, which also resyncs after a misaligned one.
  always_comb begin
    fcnt_d     = (bnd || at_end) ? 6'd0 : fcnt_q + 6'd1;
    sync_err_d = sync_err_q | (bnd ^ at_end);
  end

  always_comb begin
    dac_word_d  = dac_word_q;
    ack_d       = 4'b0000;
    cur_ch_d    = cur_ch_q;
    cur_valid_d = cur_valid_q;
    rr_d        = rr_q;
    if (bnd) begin
      if (grant_found) begin
        dac_word_d  = {CMD, 2'b00, grant_idx, grant_data, 4'h0};
        ack_d       = 4'b0001 << grant_idx;
        cur_ch_d    = grant_idx;
        cur_valid_d = 1'b1;
        rr_d        = grant_idx + 2'd1;
      end else begin
        dac_word_d  = NOP_WORD;
        cur_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_sig_q <= 1'b0;
      fcnt_q      <= 6'd0;
      rr_q        <= 2'd0;
      dac_word_q  <= NOP_WORD;
      ack_q       <= 4'b0000;
      cur_ch_q    <= 2'd0;
      cur_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      frame_sig_q <= frame_sig;
      fcnt_q      <= fcnt_d;
      rr_q        <= rr_d;
      dac_word_q  <= dac_word_d;
      ack_q       <= ack_d;
      cur_ch_q    <= cur_ch_d;
      cur_valid_q <= cur_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign dac_word  = dac_word_q;
  assign ack       = ack_q;
  assign cur_ch    = cur_ch_q;
  assign cur_valid = cur_valid_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// tb/tb_dac_channel_scheduler.sv - directed self-checking bench for dac_channel_scheduler
// Includes a minimal serializer model that drives frame_sig and shifts dac_word out MSB-first.
module tb_dac_channel_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [47:0] ch_data;
  logic        frame_sig;
  logic [23:0] dac_word;
  logic [3:0]  ack;
  logic [1:0]  cur_ch;
  logic        cur_valid;
  logic        sync_err;

  logic [5:0]  ser_cnt;
  logic        inj;
  logic        ser_bit;

  int n_checks = 0;
  int n_errors = 0;

  dac_channel_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ch_data   (ch_data),
    .frame_sig (frame_sig),
    .dac_word  (dac_word),
    .ack       (ack),
    .cur_ch    (cur_ch),
    .cur_valid (cur_valid),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) ser_cnt <= 6'd0;
    else       ser_cnt <= (ser_cnt == 6'd47) ? 6'd0 : ser_cnt + 6'd1;
  end

  assign frame_sig = (ser_cnt >= 6'd46) || inj;
  assign ser_bit   = dac_word[5'd23 - ser_cnt[5:1]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = 4'b0000;
    ch_data = 48'h0;
    inj     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_bnd(input string tag);
    int n = 0;
    while (ser_cnt != 6'd47 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ser_cnt), 32'd47);
  endtask

  function automatic logic [11:0] dval(input int f, input int i);
    return 12'(12'h300 + f * 16 + i);
  endfunction

  function automatic logic [23:0] chan_word(input logic [1:0] i, input logic [11:0] d);
    return {4'h3, 2'b00, i, d, 4'h0};
  endfunction

  function automatic logic [47:0] frame_data(input int f);
    return {dval(f, 3), dval(f, 2), dval(f, 1), dval(f, 0)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] cap;
    int slips;
    int ack_pulses;
    int ack3_seen;
    int i;

    // Idle after reset: NOP frames, boundaries at clocks 47, 95, 143, 191
    do_reset();
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_cur_valid", 32'(cur_valid), 32'd0);
    check("rst_fcnt", 32'(dut.fcnt_q), 32'd0);
    for (int k = 0; k < 200; k++) begin
      check("idle_word", 32'(dac_word), 32'hFF0000);
      check("idle_ack", 32'(ack), 32'd0);
      check("idle_sync", 32'(sync_err), 32'd0);
      check("idle_bnd", 32'(dut.bnd), (k % 48 == 47) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Single request on channel 2
    do_reset();
    repeat (10) @(negedge clk);
    req = 4'b0100;
    ch_data[35:24] = 12'hABC;
    wait_bnd("ch2_wait");
    check("ch2_pre_word", 32'(dac_word), 32'hFF0000);
    check("ch2_pre_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("ch2_word", 32'(dac_word), 32'h32ABC0);
    check("ch2_ack", 32'(ack), 32'b0100);
    check("ch2_cur_ch", 32'(cur_ch), 32'd2);
    check("ch2_cur_valid", 32'(cur_valid), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("ch2_ack_drop", 32'(ack), 32'd0);

    // All four requesting: rotation, serial bit capture, data changes while in flight
    do_reset();
    req     = 4'b1111;
    ch_data = frame_data(0);
    wait_bnd("rr_wait");
    for (int f = 0; f < 10; f++) begin
      i = f % 4;
      slips = 0;
      ack_pulses = 0;
      cap = 24'h0;
      for (int c = 0; c < 48; c++) begin
        @(negedge clk);
        if (c == 0) begin
          check("rr_ack", 32'(ack), 32'(4'b0001 << i));
          check("rr_cur_ch", 32'(cur_ch), 32'(i));
        end
        if (ack != 4'b0000) ack_pulses++;
        if (c % 2 == 0) cap[23 - c / 2] = ser_bit;
        else if (ser_bit !== cap[23 - c / 2]) slips++;
        if (c == 10) ch_data = frame_data(f + 1);
      end
      check("rr_serial_word", 32'(cap), 32'(chan_word(2'(i), dval(f, i))));
      check("rr_slips", 32'(slips), 32'd0);
      check("rr_ack_pulses", 32'(ack_pulses), 32'd1);
    end

    // Channel 1 held, channel 3 pulsed between boundaries
    do_reset();
    req = 4'b0010;
    ch_data[23:12] = 12'h123;
    wait_bnd("pulse_wait");
    ack3_seen = 0;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 48; c++) begin
        @(negedge clk);
        if (c == 0) begin
          check("pulse_ack1", 32'(ack), 32'b0010);
          check("pulse_cur_ch", 32'(cur_ch), 32'd1);
          check("pulse_word", 32'(dac_word), 32'h311230);
        end
        if (ack[3]) ack3_seen++;
        if (c == 20) req[3] = 1'b1;
        if (c == 21) req[3] = 1'b0;
      end
    end
    check("pulse_ack3_never", 32'(ack3_seen), 32'd0);

    // Extra frame_sig pulse mid-frame, then reset mid-frame with an ack pending
    do_reset();
    check("sync_pre", 32'(sync_err), 32'd0);
    repeat (19) @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    check("sync_inj_bnd", 32'(dut.bnd), 32'd1);
    @(negedge clk);
    inj = 1'b0;
    check("sync_fcnt_resync", 32'(dut.fcnt_q), 32'd0);
    check("sync_set", 32'(sync_err), 32'd1);
    repeat (100) @(negedge clk);
    check("sync_sticky", 32'(sync_err), 32'd1);
    req = 4'b0001;
    ch_data[11:0] = 12'h777;
    wait_bnd("sync_req_wait");
    @(negedge clk);
    check("sync_ack0", 32'(ack), 32'b0001);
    check("sync_word0", 32'(dac_word), 32'h307770);
    reset = 1'b1;
    #1;
    check("rst_mid_ack", 32'(ack), 32'd0);
    check("rst_mid_word", 32'(dac_word), 32'hFF0000);
    check("rst_mid_sync", 32'(sync_err), 32'd0);
    check("rst_mid_valid", 32'(cur_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
